// File: rtl/reg_file_eight_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_eight_if
//  Description : Write/read bus and debug taps of the 8x8 register file.
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_file_eight_if;
    logic       we;
    logic       inc;
    logic       dec;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       zero;
    logic [7:0] dbg_r0;
    logic [7:0] dbg_r1;
    logic [7:0] dbg_r2;
    logic [7:0] dbg_r3;
    logic [7:0] dbg_r4;
    logic [7:0] dbg_r5;
    logic [7:0] dbg_r6;
    logic [7:0] dbg_r7;

    modport master (
        output we, inc, dec, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, zero,
        input  dbg_r0, dbg_r1, dbg_r2, dbg_r3, dbg_r4, dbg_r5, dbg_r6, dbg_r7
    );

    modport slave (
        input  we, inc, dec, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, zero,
        output dbg_r0, dbg_r1, dbg_r2, dbg_r3, dbg_r4, dbg_r5, dbg_r6, dbg_r7
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_eight.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_eight
//  Description : 8-entry x 8-bit register file, 2 combinational read ports,
//                1 write port with in-place increment/decrement.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_eight #(
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_eight_if.slave  bus
);

    logic [7:0] r_mem [8];
    logic       r_zero;

    logic [7:0] w_reg [8];
    logic       w_modify;
    logic       w_commit;
    logic [7:0] w_new;
    logic       w_hit_a;
    logic       w_hit_b;

    // Architectural view of the registers; R0 collapses to a constant when hard-wired.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_view
            if ((ZERO_R0 != 0) && (gi == 0)) begin : g_hardwired
                assign w_reg[gi] = 8'h00;
            end else begin : g_stored
                assign w_reg[gi] = r_mem[gi];
            end
        end
    endgenerate

    always_comb begin
        w_modify = 1'b0;
        w_new    = w_reg[bus.waddr];
        if (bus.we) begin
            w_modify = 1'b1;
            w_new    = bus.wdata;
        end else if (bus.inc && !bus.dec) begin
            w_modify = 1'b1;
            w_new    = w_reg[bus.waddr] + 8'd1;
        end else if (bus.dec && !bus.inc) begin
            w_modify = 1'b1;
            w_new    = w_reg[bus.waddr] - 8'd1;
        end
    end

    // An access to a hard-wired R0 is dropped entirely, including the zero flag.
    assign w_commit = w_modify && !((ZERO_R0 != 0) && (bus.waddr == 3'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_zero <= 1'b0;
        end else if (w_commit) begin
            r_mem[bus.waddr] <= w_new;
            r_zero           <= (w_new == 8'h00);
        end
    end

    assign w_hit_a = (BYPASS != 0) && !rst && w_commit && (bus.raddr_a == bus.waddr);
    assign w_hit_b = (BYPASS != 0) && !rst && w_commit && (bus.raddr_b == bus.waddr);

    assign bus.rdata_a = w_hit_a ? w_new : w_reg[bus.raddr_a];
    assign bus.rdata_b = w_hit_b ? w_new : w_reg[bus.raddr_b];
    assign bus.zero    = r_zero;

    assign bus.dbg_r0 = w_reg[0];
    assign bus.dbg_r1 = w_reg[1];
    assign bus.dbg_r2 = w_reg[2];
    assign bus.dbg_r3 = w_reg[3];
    assign bus.dbg_r4 = w_reg[4];
    assign bus.dbg_r5 = w_reg[5];
    assign bus.dbg_r6 = w_reg[6];
    assign bus.dbg_r7 = w_reg[7];

endmodule
`default_nettype wire
